// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: size and state encodings plus defaults shared by the arbiter and the LSU
package bus_arbiter_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;
    localparam int MAX_LS_STREAK_DEF = 3;
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, ERR_LS} state_t;
endpackage

// File: rtl/bus_align_check.sv
// bus_align_check: flags illegal sizes and misaligned half/word data accesses
module bus_align_check
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic       o_fault
);
    always_comb o_fault = (i_size == SZ_ILL) ||
                          (i_size == SZ_HALF && i_addr_lo[0]) ||
                          (i_size == SZ_WORD && i_addr_lo != 2'b00);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory port between fetch and load/store, LS priority with IF anti-starvation
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_LS_STREAK = MAX_LS_STREAK_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [1:0]    ls_size,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_valid,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);
    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

    state_t        r_state;
    logic [SW-1:0] r_streak;
    logic          w_ls_fault;
    logic          w_ls_win;

    bus_align_check u_align (
        .i_size    (ls_size),
        .i_addr_lo (ls_addr[1:0]),
        .o_fault   (w_ls_fault)
    );

    // LS wins unless IF has already been passed over MAX_LS_STREAK times in a row
    assign w_ls_win = ls_req && (!if_req || r_streak < STREAK_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_streak  <= '0;
            if_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            ls_gnt    <= 1'b0;
            ls_valid  <= 1'b0;
            ls_rdata  <= '0;
            ls_err    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_gnt   <= 1'b0;
            ls_gnt   <= 1'b0;
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            ls_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ls_win) begin
                        ls_gnt    <= 1'b1;
                        r_streak  <= if_req ? ((r_streak == STREAK_MAX) ? STREAK_MAX : r_streak + 1'b1) : '0;
                        r_state   <= w_ls_fault ? ERR_LS : BUSY_LS;
                        mem_req   <= !w_ls_fault;
                        mem_we    <= ls_we;
                        mem_size  <= ls_size;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                    end else if (if_req) begin
                        if_gnt   <= 1'b1;
                        r_streak <= '0;
                        r_state  <= BUSY_IF;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_size <= SZ_WORD;
                        mem_addr <= {if_addr[AW-1:2], 2'b00};
                    end
                end
                BUSY_IF: begin
                    if (mem_ready) begin
                        if_rdata <= mem_rdata;
                        if_valid <= 1'b1;
                        mem_req  <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                BUSY_LS: begin
                    if (mem_ready) begin
                        ls_rdata <= mem_we ? '0 : mem_rdata;
                        ls_valid <= 1'b1;
                        mem_req  <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    ls_valid <= 1'b1;
                    ls_err   <= 1'b1;
                    ls_rdata <= '0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end
endmodule
